// File: rtl/icap_reader.sv
// Reads one 7-series configuration register through ICAPE2 (X32): sync, Type-1 read header,
// timed read window, then DESYNC. The ICAPE2 pins are exposed so the top level can arbitrate.
module icap_reader #(
  parameter int unsigned READ_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  REG_ADDR_I,
  input  logic        VALID_I,
  output logic [31:0] DATA_O,
  output logic        DATA_VALID_O,
  output logic        BUSY_O,
  output logic        ICAP_CSIB_O,
  output logic        ICAP_RDWRB_O,
  output logic [31:0] ICAP_I_O,
  input  logic [31:0] ICAP_O_I
);

  localparam logic [31:0] WordDummy  = 32'hFFFF_FFFF;
  localparam logic [31:0] WordSync   = 32'hAA99_5566;
  localparam logic [31:0] WordNoop   = 32'h2000_0000;
  localparam logic [31:0] WordCmd    = 32'h3000_8001;
  localparam logic [31:0] WordDesync = 32'h0000_000D;
  localparam logic [31:0] HdrBase    = 32'h2800_0001;
  localparam logic [3:0]  LastRead   = 4'(READ_WAIT - 1);

  typedef enum logic [3:0] {
    StIdle, StDummy, StSync, StNoopA, StRdHdr, StNoopB, StToRd,
    StRead, StRdEnd, StToWr, StCmd, StDesync, StNoopC, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] capture_q, capture_d;
  logic [31:0] data_q, data_d;
  logic        dv_q, dv_d;
  logic        busy_q, busy_d;
  logic        csib_q, csib_d;
  logic        rdwrb_q, rdwrb_d;
  logic [31:0] icap_i_q, icap_i_d;
  logic [31:0] word;

  // ICAPE2 expects every byte bit-reversed in place.
  function automatic logic [31:0] bitswap(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = v[8*b+7-i];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    capture_d = capture_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (VALID_I) begin
          state_d = StDummy;
          addr_d  = REG_ADDR_I;
        end else begin
          state_d = StIdle;
        end
      end
      StDummy: state_d = StSync;
      StSync:  state_d = StNoopA;
      StNoopA: state_d = StRdHdr;
      StRdHdr: begin
        state_d = StNoopB;
        cnt_d   = '0;
      end
      StNoopB: begin
        if (cnt_q == 4'd1) begin
          state_d = StToRd;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StToRd: begin
        state_d = StRead;
        cnt_d   = '0;
      end
      StRead: begin
        if (cnt_q == LastRead) begin
          state_d   = StRdEnd;
          capture_d = bitswap(ICAP_O_I);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRdEnd:  state_d = StToWr;
      StToWr:   state_d = StCmd;
      StCmd:    state_d = StDesync;
      StDesync: begin
        state_d = StNoopC;
        cnt_d   = '0;
      end
      StNoopC: begin
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that every pin comes straight from a flop.
  always_comb begin
    word    = WordDummy;
    csib_d  = 1'b1;
    rdwrb_d = 1'b0;
    busy_d  = 1'b1;
    dv_d    = 1'b0;
    data_d  = data_q;
    case (state_d)
      StIdle:  busy_d = 1'b0;
      StDummy: csib_d = 1'b0;
      StSync: begin
        csib_d = 1'b0;
        word   = WordSync;
      end
      StNoopA, StNoopB, StNoopC: begin
        csib_d = 1'b0;
        word   = WordNoop;
      end
      StRdHdr: begin
        csib_d = 1'b0;
        word   = HdrBase | ({27'd0, addr_q} << 13);
      end
      StToRd, StRdEnd: rdwrb_d = 1'b1;
      StRead: begin
        csib_d  = 1'b0;
        rdwrb_d = 1'b1;
      end
      StCmd: begin
        csib_d = 1'b0;
        word   = WordCmd;
      end
      StDesync: begin
        csib_d = 1'b0;
        word   = WordDesync;
      end
      StDone: begin
        busy_d = 1'b0;
        dv_d   = 1'b1;
        data_d = capture_q;
      end
      default: ;
    endcase
    icap_i_d = bitswap(word);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      capture_q <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      csib_q    <= 1'b1;
      rdwrb_q   <= 1'b0;
      icap_i_q  <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      capture_q <= capture_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      csib_q    <= csib_d;
      rdwrb_q   <= rdwrb_d;
      icap_i_q  <= icap_i_d;
    end
  end

  assign DATA_O       = data_q;
  assign DATA_VALID_O = dv_q;
  assign BUSY_O       = busy_q;
  assign ICAP_CSIB_O  = csib_q;
  assign ICAP_RDWRB_O = rdwrb_q;
  assign ICAP_I_O     = icap_i_q;

endmodule

// File: tb/tb_icap_reader.sv
// Self-checking bench for icap_reader: per-cycle expected ICAP traffic from the command table,
// random readback data, ignored/back-to-back requests and mid-sequence reset.
module tb_icap_reader;

  localparam int RW   = 4;
  localparam int LAST = 14 + RW;

  logic        clk = 1'b0;
  logic        RST;
  logic [4:0]  REG_ADDR_I;
  logic        VALID_I;
  logic [31:0] DATA_O;
  logic        DATA_VALID_O;
  logic        BUSY_O;
  logic        ICAP_CSIB_O;
  logic        ICAP_RDWRB_O;
  logic [31:0] ICAP_I_O;
  logic [31:0] ICAP_O_I;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_data;
  logic        prev_rd;

  always #5 clk = ~clk;

  icap_reader #(.READ_WAIT(RW)) dut (
    .CLK          (clk),
    .RST          (RST),
    .REG_ADDR_I   (REG_ADDR_I),
    .VALID_I      (VALID_I),
    .DATA_O       (DATA_O),
    .DATA_VALID_O (DATA_VALID_O),
    .BUSY_O       (BUSY_O),
    .ICAP_CSIB_O  (ICAP_CSIB_O),
    .ICAP_RDWRB_O (ICAP_RDWRB_O),
    .ICAP_I_O     (ICAP_I_O),
    .ICAP_O_I     (ICAP_O_I)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] v);
    logic [7:0]  b;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      b = v[8*k +: 8];
      r[8*k +: 8] = {<<{b}};
    end
    return r;
  endfunction

  // Expected pins for cycle c of a read (cycle 0 = VALID_I), word given before bit swap.
  function automatic void exp_cycle(input int c, input logic [4:0] a, output logic cs,
                                    output logic rd, output logic [31:0] w, output bit wchk);
    cs = 1'b0; rd = 1'b0; w = 32'hFFFF_FFFF; wchk = 1'b1;
    if (c == 2) w = 32'hAA99_5566;
    else if (c == 3 || c == 5 || c == 6) w = 32'h2000_0000;
    else if (c == 4) w = 32'h2800_0001 + 32'(a) * 8192;
    else if (c == 7) begin cs = 1'b1; rd = 1'b1; wchk = 1'b0; end
    else if (c >= 8 && c <= 7 + RW) rd = 1'b1;
    else if (c == 8 + RW) begin cs = 1'b1; rd = 1'b1; wchk = 1'b0; end
    else if (c == 9 + RW) begin cs = 1'b1; wchk = 1'b0; end
    else if (c == 10 + RW) w = 32'h3000_8001;
    else if (c == 11 + RW) w = 32'h0000_000D;
    else if (c == 12 + RW || c == 13 + RW) w = 32'h2000_0000;
    else if (c == LAST) begin cs = 1'b1; wchk = 1'b0; end
  endfunction

  task automatic rw_check();
    if (ICAP_RDWRB_O !== prev_rd) chk("rdwrb_toggle_csib", ICAP_CSIB_O, 1);
    prev_rd = ICAP_RDWRB_O;
  endtask

  task automatic idle_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      VALID_I = 1'b0; RST = 1'b0; ICAP_O_I = $urandom; REG_ADDR_I = 5'($urandom);
      @(negedge clk); rw_check();
      chk("idle_csib", ICAP_CSIB_O, 1);
      chk("idle_rdwrb", ICAP_RDWRB_O, 0);
      chk("idle_i", ICAP_I_O, 32'hFFFF_FFFF);
      chk("idle_busy", BUSY_O, 0);
      chk("idle_dv", DATA_VALID_O, 0);
      chk("idle_data", DATA_O, last_data);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input bit started, input int ign1, input int ign2,
                         input int rst_at, input bit chain, input logic [4:0] next_a,
                         input bit use_fixed, input logic [31:0] fixed_o);
    logic [31:0] cap, o, w;
    logic        cs, rd;
    bit          wchk;
    cap = '0;
    if (!started) begin
      @(posedge clk); #1;
      REG_ADDR_I = a; VALID_I = 1'b1; RST = 1'b0;
      @(negedge clk); rw_check();
    end
    for (int c = 1; c <= LAST; c++) begin
      @(posedge clk); #1;
      VALID_I = (c == ign1 || c == ign2 || (c == LAST && chain));
      REG_ADDR_I = (c == LAST && chain) ? next_a : 5'($urandom);
      o = use_fixed ? fixed_o : $urandom;
      ICAP_O_I = o;
      if (c == 7 + RW) cap = swap(o);
      RST = (c == rst_at);
      @(negedge clk); rw_check();
      exp_cycle(c, a, cs, rd, w, wchk);
      chk($sformatf("csib_c%0d", c), ICAP_CSIB_O, cs);
      chk($sformatf("rdwrb_c%0d", c), ICAP_RDWRB_O, rd);
      if (wchk) chk($sformatf("icap_i_c%0d", c), ICAP_I_O, swap(w));
      chk($sformatf("busy_c%0d", c), BUSY_O, c != LAST);
      if (c == LAST) last_data = cap;
      chk($sformatf("dv_c%0d", c), DATA_VALID_O, c == LAST);
      chk($sformatf("data_c%0d", c), DATA_O, last_data);
      if (c == rst_at) begin
        @(posedge clk); #1;
        RST = 1'b0; VALID_I = 1'b0;
        @(negedge clk); rw_check();
        last_data = '0;
        chk("rst_csib", ICAP_CSIB_O, 1);
        chk("rst_rdwrb", ICAP_RDWRB_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_dv", DATA_VALID_O, 0);
        chk("rst_data", DATA_O, 0);
        return;
      end
    end
  endtask

  initial begin
    RST = 1'b1; VALID_I = 1'b0; REG_ADDR_I = '0; ICAP_O_I = '0;
    prev_rd = 1'b0; last_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_csib", ICAP_CSIB_O, 1);
    chk("reset_rdwrb", ICAP_RDWRB_O, 0);
    chk("reset_i", ICAP_I_O, 32'hFFFF_FFFF);
    chk("reset_data", DATA_O, 0);
    chk("reset_dv", DATA_VALID_O, 0);
    chk("reset_busy", BUSY_O, 0);
    idle_checks(2);

    // IDCODE read with known readback word.
    do_read(5'h0C, 1'b0, 0, 0, 0, 1'b0, 5'h0, 1'b1, 32'hC4E6_C090);
    idle_checks(1);
    chk("idcode_data_abs", DATA_O, 32'h2367_0309);

    // BOOTSTS read; pins also checked against the literal header word.
    do_read(5'h16, 1'b0, 0, 0, 0, 1'b0, 5'h0, 1'b0, 32'h0);
    idle_checks(2);

    // Requests while busy are ignored; a request in DONE chains a second read.
    do_read(5'h07, 1'b0, 3, 10, 0, 1'b1, 5'h10, 1'b0, 32'h0);
    do_read(5'h10, 1'b1, 0, 0, 0, 1'b0, 5'h0, 1'b0, 32'h0);
    idle_checks(2);

    for (int k = 0; k < 3; k++) begin
      do_read(5'($urandom), 1'b0, 0, 0, 0, 1'b0, 5'h0, 1'b0, 32'h0);
      idle_checks(1);
    end

    // Reset in the middle of the read window, then a fresh request.
    do_read(5'h16, 1'b0, 0, 0, 9, 1'b0, 5'h0, 1'b0, 32'h0);
    idle_checks(3);
    do_read(5'h0C, 1'b0, 0, 0, 0, 1'b0, 5'h0, 1'b0, 32'h0);
    idle_checks(1);

    // Reset and request together: request dropped.
    @(posedge clk); #1;
    RST = 1'b1; VALID_I = 1'b1; REG_ADDR_I = 5'h0C;
    @(negedge clk); rw_check();
    @(posedge clk); #1;
    RST = 1'b0; VALID_I = 1'b0;
    @(negedge clk); rw_check();
    last_data = '0;
    chk("rstvalid_busy", BUSY_O, 0);
    chk("rstvalid_csib", ICAP_CSIB_O, 1);
    chk("rstvalid_data", DATA_O, 0);
    idle_checks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
